// File: rtl/seq_detect_pkg.sv
// Shared constants and helpers for the parametrised sequence detector.
package seq_detect_pkg;

  localparam int SEQDET_MAX_LEN_DEF = 8;
  localparam int SEQDET_CNT_W_DEF   = 8;

  // Map a requested pattern length onto the supported range 1..max_len.
  function automatic int clamp_len(input int cfg_len, input int max_len);
    if (cfg_len < 1)       return 1;
    if (cfg_len > max_len) return max_len;
    return cfg_len;
  endfunction

endpackage

// File: rtl/seq_match_cnt.sv
// Saturating match counter; holds at all-ones instead of wrapping.
module seq_match_cnt #(
  parameter int CNT_W = 8
)(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  output logic [CNT_W-1:0] cnt
);

  // Count enabled cycles, saturating at the top value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                cnt <= '0;
    else if (en && cnt != '1)  cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-configurable serial bit-sequence detector with registered match pulse.
// Optional saturating match counter enabled by defining SEQDET_CNT_EN.
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int MAX_LEN = SEQDET_MAX_LEN_DEF,
  parameter int LEN_W   = $clog2(MAX_LEN+1),
  parameter int CNT_W   = SEQDET_CNT_W_DEF
)(
  input  logic               clk,
  input  logic               reset,
  input  logic               w,
  input  logic               w_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               z,
  output logic [CNT_W-1:0]   match_cnt
);

  logic [MAX_LEN-1:0] hist, hist_n, pat, mask;
  logic [LEN_W-1:0]   fill, fill_n, len, len_clamped;
  logic               overlap;
  logic               match;

  assign len_clamped = LEN_W'(clamp_len(int'(cfg_len), MAX_LEN));

  // Next history/fill and match decision for the current sample.
  always_comb begin
    hist_n = {hist[MAX_LEN-2:0], w};
    fill_n = (fill == LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
    mask   = '0;
    for (int i = 0; i < MAX_LEN; i++) mask[i] = (i < int'(len));
    // A simultaneous cfg_load discards the sample, so it can never match.
    match  = w_valid && !cfg_load && (fill_n >= len) &&
             ((hist_n & mask) == (pat & mask));
  end

  // Config, history and registered match pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pat     <= '0;
      len     <= LEN_W'(1);
      overlap <= 1'b1;
      hist    <= '0;
      fill    <= '0;
      z       <= 1'b0;
    end else if (cfg_load) begin
      pat     <= cfg_pattern;
      len     <= len_clamped;
      overlap <= cfg_overlap;
      hist    <= '0;
      fill    <= '0;
      z       <= 1'b0;
    end else begin
      z <= match;
      if (w_valid) begin
        hist <= hist_n;
        // Non-overlap restarts by emptying fill; stale hist bits are gated off.
        fill <= (match && !overlap) ? '0 : fill_n;
      end
    end
  end

`ifdef SEQDET_CNT_EN
  seq_match_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (match),
    .cnt   (match_cnt)
  );
`else
  assign match_cnt = '0;
`endif

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param; counter checks adapt to SEQDET_CNT_EN.
module tb_seq_detect_param;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
`ifdef SEQDET_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic             w, w_valid, cfg_load, cfg_overlap;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             z, z2;
  logic [7:0]       match_cnt;
  logic [1:0]       match_cnt2;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  seq_detect_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .w(w), .w_valid(w_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .z(z), .match_cnt(match_cnt)
  );

  seq_detect_param #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .w(w), .w_valid(w_valid), .cfg_load(cfg_load),
    .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
    .z(z2), .match_cnt(match_cnt2)
  );

  // One clock with the given sample; outputs are readable on return.
  task automatic drive(input logic b, input logic v);
    w = b; w_valid = v;
    @(posedge clk); #1;
    w_valid = 1'b0;
  endtask

  task automatic load_cfg(input logic [7:0] p, input logic [3:0] l, input logic o);
    cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_load = 1'b1;
    @(posedge clk); #1;
    cfg_load = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (z !== 1'b0) begin failures++; $display("FAIL reset_z: got %b want 0", z); end
    checks++; if (match_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt: got %0d want 0", match_cnt); end
    // Build up to a match, then reset asynchronously while z is high.
    load_cfg(8'b1011, 4'd4, 1'b1);
    drive(1, 1); drive(0, 1); drive(1, 1); drive(1, 1);
    exp_cnt++;
    checks++; if (z !== 1'b1) begin failures++; $display("FAIL reset_pre_z: got %b want 1", z); end
    #2 reset = 1'b0;
    #1;
    checks++; if (z !== 1'b0) begin failures++; $display("FAIL reset_async_z: got %b want 0", z); end
    checks++; if (match_cnt !== 8'd0) begin failures++; $display("FAIL reset_async_cnt: got %0d want 0", match_cnt); end
    exp_cnt = 0;
    @(posedge clk); #1;
    reset = 1'b1;
    // Reset config is pattern 0, len 1: a valid 0 matches, a valid 1 does not.
    drive(1, 1);
    checks++; if (z !== 1'b0) begin failures++; $display("FAIL reset_default_w1: got %b want 0", z); end
    drive(0, 1); exp_cnt++;
    checks++; if (z !== 1'b1) begin failures++; $display("FAIL reset_default_w0: got %b want 1", z); end
    drive(0, 0);
    checks++; if (z !== 1'b0) begin failures++; $display("FAIL reset_idle_z: got %b want 0", z); end
  endtask

  task automatic test_overlap();
    logic bits [0:6] = '{1, 0, 1, 1, 0, 1, 1};
    logic expz [0:6] = '{0, 0, 0, 1, 0, 0, 1};
    do_reset();
    load_cfg(8'b1011, 4'd4, 1'b1);
    for (int i = 0; i < 7; i++) begin
      drive(bits[i], 1);
      if (expz[i]) exp_cnt++;
      checks++; if (z !== expz[i]) begin failures++; $display("FAIL overlap_z bit%0d: got %b want %b", i+1, z, expz[i]); end
    end
    checks++; if (match_cnt !== (CNT_EN ? 8'(exp_cnt) : 8'd0)) begin failures++; $display("FAIL overlap_cnt: got %0d want %0d", match_cnt, CNT_EN ? exp_cnt : 0); end
  endtask

  task automatic test_no_overlap();
    logic bits [0:6] = '{1, 0, 1, 1, 0, 1, 1};
    logic expz [0:6] = '{0, 0, 0, 1, 0, 0, 0};
    do_reset();
    load_cfg(8'b1011, 4'd4, 1'b0);
    for (int i = 0; i < 7; i++) begin
      drive(bits[i], 1);
      if (expz[i]) exp_cnt++;
      checks++; if (z !== expz[i]) begin failures++; $display("FAIL nooverlap_z bit%0d: got %b want %b", i+1, z, expz[i]); end
    end
    checks++; if (match_cnt !== (CNT_EN ? 8'(exp_cnt) : 8'd0)) begin failures++; $display("FAIL nooverlap_cnt: got %0d want %0d", match_cnt, CNT_EN ? exp_cnt : 0); end
  endtask

  task automatic test_idle_gap();
    // Invalid cycles carry w=1 to prove they are ignored.
    logic bits [0:6] = '{1, 0, 1, 1, 1, 1, 1};
    logic vld  [0:6] = '{1, 1, 0, 0, 0, 1, 1};
    logic expz [0:6] = '{0, 0, 0, 0, 0, 0, 1};
    load_cfg(8'b1011, 4'd4, 1'b1);
    for (int i = 0; i < 7; i++) begin
      drive(bits[i], vld[i]);
      if (expz[i]) exp_cnt++;
      checks++; if (z !== expz[i]) begin failures++; $display("FAIL idle_gap_z step%0d: got %b want %b", i+1, z, expz[i]); end
    end
    checks++; if (match_cnt !== (CNT_EN ? 8'(exp_cnt) : 8'd0)) begin failures++; $display("FAIL idle_gap_cnt: got %0d want %0d", match_cnt, CNT_EN ? exp_cnt : 0); end
  endtask

  task automatic test_len_clamp();
    logic bits0 [0:2] = '{1, 1, 0};
    logic expz0 [0:2] = '{1, 1, 0};
    logic [7:0] p8 = 8'b1011_0011;
    // len 0 acts as 1; non-overlap still permits back-to-back matches.
    load_cfg(8'b0000_0001, 4'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(bits0[i], 1);
      if (expz0[i]) exp_cnt++;
      checks++; if (z !== expz0[i]) begin failures++; $display("FAIL len0_z bit%0d: got %b want %b", i+1, z, expz0[i]); end
    end
    // len 15 acts as 8: full pattern matches on its eighth bit only.
    load_cfg(p8, 4'd15, 1'b1);
    for (int i = 7; i >= 0; i--) begin
      drive(p8[i], 1);
      checks++;
      if (z !== (i == 0)) begin failures++; $display("FAIL len15_z bit%0d: got %b want %b", 8-i, z, i == 0); end
    end
    exp_cnt++;
    checks++; if (match_cnt !== (CNT_EN ? 8'(exp_cnt) : 8'd0)) begin failures++; $display("FAIL len_clamp_cnt: got %0d want %0d", match_cnt, CNT_EN ? exp_cnt : 0); end
  endtask

  task automatic test_load_collision();
    load_cfg(8'b1011, 4'd4, 1'b1);
    drive(1, 1); drive(0, 1); drive(1, 1);
    // Final bit arrives with cfg_load: sample discarded, history cleared.
    cfg_pattern = 8'b1011; cfg_len = 4'd4; cfg_overlap = 1'b1; cfg_load = 1'b1;
    drive(1, 1);
    cfg_load = 1'b0;
    checks++; if (z !== 1'b0) begin failures++; $display("FAIL collide_z: got %b want 0", z); end
    drive(1, 1);
    checks++; if (z !== 1'b0) begin failures++; $display("FAIL collide_after_z: got %b want 0", z); end
    checks++; if (match_cnt !== (CNT_EN ? 8'(exp_cnt) : 8'd0)) begin failures++; $display("FAIL collide_cnt: got %0d want %0d", match_cnt, CNT_EN ? exp_cnt : 0); end
    drive(0, 1); drive(1, 1); drive(1, 1);
    exp_cnt++;
    checks++; if (z !== 1'b1) begin failures++; $display("FAIL collide_rematch_z: got %b want 1", z); end
  endtask

  task automatic test_saturate();
    do_reset();
    load_cfg(8'b1, 4'd1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1);
      exp_cnt++;
      checks++; if (z2 !== 1'b1) begin failures++; $display("FAIL sat_z match%0d: got %b want 1", i+1, z2); end
    end
    checks++; if (match_cnt2 !== (CNT_EN ? 2'd3 : 2'd0)) begin failures++; $display("FAIL sat_cnt2: got %0d want %0d", match_cnt2, CNT_EN ? 3 : 0); end
    checks++; if (match_cnt !== (CNT_EN ? 8'(exp_cnt) : 8'd0)) begin failures++; $display("FAIL sat_cnt8: got %0d want %0d", match_cnt, CNT_EN ? exp_cnt : 0); end
  endtask

  initial begin
    reset = 1'b0; w = 1'b0; w_valid = 1'b0; cfg_load = 1'b0;
    cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
    #2;
    test_reset();
    test_overlap();
    test_no_overlap();
    test_idle_gap();
    test_len_clamp();
    test_load_collision();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
